// File: rtl/win_mul_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : win_mul_seq_if
// Brief   : Operand/product handshake bundle for the sequential multiplier.
// Revision: 1.0 - initial release
// ============================================================================
interface win_mul_seq_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic [1:0]           sign;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   mul_out;

    modport master (
        output in_valid, mul_a, mul_b, sign, out_ready,
        input  in_ready, out_valid, mul_out
    );

    modport slave (
        input  in_valid, mul_a, mul_b, sign, out_ready,
        output in_ready, out_valid, mul_out
    );
endinterface
`default_nettype wire

// File: rtl/win_mul_seq.sv
`default_nettype none
// ============================================================================
// Module  : win_mul_seq
// Brief   : Iterative shift-add multiplier, per-operand sign mode, zero early-out.
// Revision: 1.0 - initial release
// ============================================================================
module win_mul_seq #(
    parameter int WIDTH = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    win_mul_seq_if.slave  bus
);
    localparam int              c_CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
    localparam logic [1:0]      c_IDLE = 2'd0;
    localparam logic [1:0]      c_CALC = 2'd1;
    localparam logic [1:0]      c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [c_CW-1:0]    r_cnt;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_out;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_zero;
    logic               w_last;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_acc_nxt;

    // Magnitudes are unsigned WIDTH bits, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
    assign w_neg_a   = bus.sign[1] & bus.mul_a[WIDTH-1];
    assign w_neg_b   = bus.sign[0] & bus.mul_b[WIDTH-1];
    assign w_mag_a   = w_neg_a ? -bus.mul_a : bus.mul_a;
    assign w_mag_b   = w_neg_b ? -bus.mul_b : bus.mul_b;
    assign w_zero    = (bus.mul_a == '0) | (bus.mul_b == '0);
    assign w_accept  = bus.in_valid & w_in_ready;
    assign w_last    = (r_cnt == c_LAST);
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_nxt = w_zero ? c_DONE : c_CALC;
            c_CALC:  if (w_last) w_state_nxt = c_DONE;
            c_DONE:  if (bus.out_ready) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            c_IDLE:  w_in_ready  = ~rst;
            c_DONE:  w_out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_out    <= '0;
        end else begin
            if (r_state == c_IDLE && w_accept) begin
                r_neg    <= w_neg_a ^ w_neg_b;
                r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                r_mplier <= w_mag_b;
                r_acc    <= '0;
                r_cnt    <= '0;
                if (w_zero) r_out <= '0;
            end else if (r_state == c_CALC) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + c_CW'(1);
                if (w_last) r_out <= r_neg ? -w_acc_nxt : w_acc_nxt;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.mul_out   = r_out;
endmodule
`default_nettype wire
